// File: rtl/piezo_note_sequencer_if.sv
// Sound-effect request handshake between the requesters and the note sequencer.
// The master drives valid/code, and the sequencer answers with ready.
interface piezo_note_sequencer_if;
  logic       req_valid;
  logic [3:0] req_code;
  logic       req_ready;

  modport master (
    output req_valid,
    output req_code,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_code,
    output req_ready
  );
endinterface

// File: rtl/piezo_note_sequencer.sv
// Four-note piezo effect sequencer with a one-deep pending slot.
// A warning effect (code 12) pre-empts any other effect.
module piezo_note_sequencer #(
  parameter int NOTE_TICKS = 250000,
  parameter int GAP_TICKS  = 50000,
  parameter int CNT_W      = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  piezo_note_sequencer_if.slave  rq,
  output logic [3:0]             note_state,
  output logic [2:0]             note_played,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP
  } state_e;

  localparam logic [CNT_W-1:0] NOTE_LAST =
    CNT_W'(NOTE_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [3:0] WARN = 4'd12;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [2:0]       note_q, note_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       code_q, code_d;
  logic             pend_v_q, pend_v_d;
  logic [3:0]       pend_q, pend_d;
  logic [2:0]       played_q, played_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic is_warn;
  logic code_ok;
  logic acc;
  logic seq_end;

  assign is_warn = (rq.req_code == WARN);
  assign code_ok = (rq.req_code != 4'd0) &&
                   (rq.req_code <= WARN);
  assign rq.req_ready = (state_q == S_IDLE) ||
                        !pend_v_q || is_warn;
  // Invalid codes are accepted but never acted on.
  assign acc = rq.req_valid && rq.req_ready && code_ok;
  assign seq_end = (state_q == S_PLAY) &&
                   (note_q == 3'd4) &&
                   (cnt_q == NOTE_LAST);

  always_comb begin
    state_d  = state_q;
    note_d   = note_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    pend_v_d = pend_v_q;
    pend_d   = pend_q;
    unique case (state_q)
      S_IDLE: begin
        if (acc) begin
          state_d = S_PLAY;
          note_d  = 3'd1;
          cnt_d   = '0;
          code_d  = rq.req_code;
        end
      end
      S_PLAY: begin
        if (cnt_q != NOTE_LAST) begin
          cnt_d = cnt_q + CNT_ONE;
        end else if (note_q != 3'd4) begin
          cnt_d = '0;
          if (GAP_TICKS == 0) begin
            note_d = note_q + 3'd1;
          end else begin
            state_d = S_GAP;
          end
        end else if (pend_v_q) begin
          note_d   = 3'd1;
          cnt_d    = '0;
          code_d   = pend_q;
          pend_v_d = 1'b0;
        end else if (acc && !is_warn) begin
          note_d = 3'd1;
          cnt_d  = '0;
          code_d = rq.req_code;
        end else begin
          state_d = S_IDLE;
          note_d  = 3'd0;
          cnt_d   = '0;
          code_d  = 4'd0;
        end
      end
      S_GAP: begin
        if (cnt_q != GAP_LAST) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          state_d = S_PLAY;
          note_d  = note_q + 3'd1;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Requests arriving while busy: pre-empt or park in the slot.
    if ((state_q != S_IDLE) && acc) begin
      if (is_warn) begin
        if (code_q != WARN) begin
          state_d  = S_PLAY;
          note_d   = 3'd1;
          cnt_d    = '0;
          code_d   = WARN;
          pend_v_d = pend_v_q;
        end
      end else if (!(seq_end && !pend_v_q)) begin
        pend_v_d = 1'b1;
        pend_d   = rq.req_code;
      end
    end

    played_d = (state_d == S_PLAY) ? note_d : 3'd0;
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_PLAY) &&
               (note_d == 3'd4) &&
               (cnt_d == NOTE_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      note_q   <= 3'd0;
      cnt_q    <= '0;
      code_q   <= 4'd0;
      pend_v_q <= 1'b0;
      pend_q   <= 4'd0;
      played_q <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      note_q   <= note_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      pend_v_q <= pend_v_d;
      pend_q   <= pend_d;
      played_q <= played_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign note_state  = code_q;
  assign note_played = played_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_piezo_note_sequencer.sv
// Directed bench for the piezo note sequencer.
// Instance a uses 4/2 note/gap ticks, and instance b uses 4/0.
module tb_piezo_note_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  piezo_note_sequencer_if ifa ();
  piezo_note_sequencer_if ifb ();

  logic [3:0] a_ns, b_ns;
  logic [2:0] a_np, b_np;
  logic       a_busy, b_busy;
  logic       a_done, b_done;

  piezo_note_sequencer #(
    .NOTE_TICKS(4),
    .GAP_TICKS (2),
    .CNT_W     (20)
  ) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .rq         (ifa),
    .note_state (a_ns),
    .note_played(a_np),
    .busy       (a_busy),
    .done       (a_done)
  );

  piezo_note_sequencer #(
    .NOTE_TICKS(4),
    .GAP_TICKS (0),
    .CNT_W     (20)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .rq         (ifb),
    .note_state (b_ns),
    .note_played(b_np),
    .busy       (b_busy),
    .done       (b_done)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [3:0] c);
    ifa.req_valid = v;
    ifa.req_code  = c;
    #1;
  endtask

  task automatic set_b(input logic v, input logic [3:0] c);
    ifb.req_valid = v;
    ifb.req_code  = c;
    #1;
  endtask

  // Note index heard on cycle c of a 4/2 sequence.
  function automatic int exp_np_a(input int c);
    int p;
    p = (c - 1) % 6;
    return (p < 4) ? ((c - 1) / 6 + 1) : 0;
  endfunction

  initial begin
    int nb;
    int nd;
    ifa.req_valid = 1'b0;
    ifa.req_code  = 4'd0;
    ifb.req_valid = 1'b0;
    ifb.req_code  = 4'd0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ns", a_ns, 0);
    chk("rst_np", a_np, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_b_busy", b_busy, 0);
    @(negedge clk);
    rst = 1'b1;
    step(1);

    // single effect with gaps
    set_a(1'b1, 4'd1);
    chk("t1_rdy", ifa.req_ready, 1);
    step(1);
    set_a(1'b0, 4'd0);
    nb = 0;
    for (int c = 1; c <= 22; c++) begin
      chk($sformatf("t1_np_c%0d", c), a_np, exp_np_a(c));
      chk($sformatf("t1_ns_c%0d", c), a_ns, 1);
      chk($sformatf("t1_done_c%0d", c), a_done,
          (c == 22) ? 1 : 0);
      nb += int'(a_busy);
      if (c < 22) step(1);
    end
    chk("t1_busy_cycles", nb, 22);
    step(1);
    chk("t1_end_ns", a_ns, 0);
    chk("t1_end_np", a_np, 0);
    chk("t1_end_busy", a_busy, 0);
    chk("t1_end_done", a_done, 0);

    // pending slot and refusal
    set_a(1'b1, 4'd5);
    step(1);
    set_a(1'b0, 4'd0);
    step(6);
    chk("t2_np_c7", a_np, 2);
    set_a(1'b1, 4'd9);
    chk("t2_rdy9", ifa.req_ready, 1);
    step(1);
    set_a(1'b0, 4'd0);
    step(5);
    chk("t2_np_c13", a_np, 3);
    set_a(1'b0, 4'd12);
    chk("t2_rdy12_full", ifa.req_ready, 1);
    set_a(1'b1, 4'd3);
    chk("t2_rdy3_full", ifa.req_ready, 0);
    step(1);
    set_a(1'b0, 4'd0);
    step(8);
    chk("t2_done5", a_done, 1);
    chk("t2_ns5", a_ns, 5);
    chk("t2_np4", a_np, 4);
    step(1);
    chk("t2_ns9", a_ns, 9);
    chk("t2_np1", a_np, 1);
    chk("t2_done_off", a_done, 0);
    chk("t2_busy9", a_busy, 1);
    set_a(1'b0, 4'd3);
    chk("t2_slot_freed", ifa.req_ready, 1);
    set_a(1'b0, 4'd0);
    step(21);
    chk("t2_done9", a_done, 1);
    chk("t2_ns9_end", a_ns, 9);
    step(1);
    chk("t2_idle_busy", a_busy, 0);
    chk("t2_idle_ns", a_ns, 0);

    // warning pre-empts during a gap
    set_a(1'b1, 4'd8);
    step(1);
    set_a(1'b0, 4'd0);
    step(10);
    chk("t3_gap_np", a_np, 0);
    chk("t3_gap_ns", a_ns, 8);
    set_a(1'b1, 4'd12);
    step(1);
    set_a(1'b0, 4'd0);
    chk("t3_ns12", a_ns, 12);
    chk("t3_np1", a_np, 1);
    chk("t3_no_done", a_done, 0);
    nb = int'(a_busy);
    nd = int'(a_done);
    for (int i = 2; i <= 22; i++) begin
      step(1);
      nb += int'(a_busy);
      nd += int'(a_done);
    end
    chk("t3_done_cnt", nd, 1);
    chk("t3_done_last", a_done, 1);
    chk("t3_busy_cycles", nb, 22);
    step(1);
    chk("t3_idle", a_busy, 0);

    // repeated warning is dropped
    set_a(1'b1, 4'd12);
    step(1);
    set_a(1'b0, 4'd0);
    step(4);
    set_a(1'b1, 4'd12);
    chk("t4_rdy12", ifa.req_ready, 1);
    step(1);
    set_a(1'b0, 4'd0);
    chk("t4_c6_np", a_np, 0);
    chk("t4_c6_ns", a_ns, 12);
    step(1);
    chk("t4_c7_np", a_np, 2);
    step(15);
    chk("t4_done", a_done, 1);
    step(1);
    chk("t4_idle", a_busy, 0);
    set_a(1'b1, 4'd0);
    chk("t4_rdy0", ifa.req_ready, 1);
    step(1);
    set_a(1'b0, 4'd0);
    chk("t4_c0_busy", a_busy, 0);
    chk("t4_c0_ns", a_ns, 0);
    set_a(1'b1, 4'd14);
    step(1);
    set_a(1'b0, 4'd0);
    chk("t4_c14_busy", a_busy, 0);
    chk("t4_c14_np", a_np, 0);
    chk("t4_c14_ns", a_ns, 0);

    // no gaps, back-to-back start
    set_b(1'b1, 4'd4);
    step(1);
    set_b(1'b0, 4'd0);
    for (int c = 1; c <= 16; c++) begin
      chk($sformatf("t5_np_c%0d", c), b_np,
          (c - 1) / 4 + 1);
      chk($sformatf("t5_busy_c%0d", c), b_busy, 1);
      chk($sformatf("t5_done_c%0d", c), b_done,
          (c == 16) ? 1 : 0);
      if (c < 16) step(1);
    end
    set_b(1'b1, 4'd6);
    chk("t5_rdy6", ifb.req_ready, 1);
    step(1);
    set_b(1'b0, 4'd0);
    chk("t5_ns6", b_ns, 6);
    chk("t5_np1", b_np, 1);
    chk("t5_done_off", b_done, 0);
    step(15);
    chk("t5_done6", b_done, 1);
    step(1);
    chk("t5_idle", b_busy, 0);

    // async reset mid-note with slot full
    set_a(1'b1, 4'd2);
    step(1);
    set_a(1'b0, 4'd0);
    step(6);
    set_a(1'b1, 4'd10);
    step(1);
    set_a(1'b0, 4'd0);
    step(6);
    chk("t6_pre_np", a_np, 3);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_ns", a_ns, 0);
    chk("t6_rst_np", a_np, 0);
    chk("t6_rst_busy", a_busy, 0);
    chk("t6_rst_done", a_done, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step(2);
    chk("t6_idle_busy", a_busy, 0);
    chk("t6_idle_ns", a_ns, 0);
    set_a(1'b1, 4'd1);
    step(1);
    set_a(1'b0, 4'd3);
    chk("t6_slot_empty", ifa.req_ready, 1);
    chk("t6_ns1", a_ns, 1);
    set_a(1'b0, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
